// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and defaults for the FFT butterfly-stage blocks
package fft_pkg;

   localparam int DEFAULT_WIDTH      = 10;
   localparam int DEFAULT_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2
   } seq_state_t;

   typedef logic signed [DEFAULT_WIDTH-1:0] sample_t;

endpackage

// File: rtl/bf_seq_mux_if.sv
// rtl/bf_seq_mux_if.sv - butterfly result input and vector stream output bundle
interface bf_seq_mux_if
   import fft_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

   logic                                     in_valid;
   logic                                     in_ready;
   logic                                     sw;
   logic signed [0:DATA_WIDTH-1][WIDTH-1:0]  add_re;
   logic signed [0:DATA_WIDTH-1][WIDTH-1:0]  add_im;
   logic signed [0:DATA_WIDTH-1][WIDTH-1:0]  sub_re;
   logic signed [0:DATA_WIDTH-1][WIDTH-1:0]  sub_im;

   logic                                     out_valid;
   logic                                     out_ready;
   logic                                     out_sel;
   logic                                     out_last;
   logic signed [0:DATA_WIDTH-1][WIDTH-1:0]  dout_re;
   logic signed [0:DATA_WIDTH-1][WIDTH-1:0]  dout_im;

   modport master (
      output in_valid, sw, add_re, add_im, sub_re, sub_im, out_ready,
      input  in_ready, out_valid, out_sel, out_last, dout_re, dout_im
   );

   modport slave (
      input  in_valid, sw, add_re, add_im, sub_re, sub_im, out_ready,
      output in_ready, out_valid, out_sel, out_last, dout_re, dout_im
   );

endinterface

// File: rtl/bf_seq_mux.sv
// rtl/bf_seq_mux.sv - registered add/sub vector sequencer with valid/ready output
module bf_seq_mux
   import fft_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter bit PASS_MODE  = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   bf_seq_mux_if.slave bus
);

   seq_state_t state, state_nxt;

   logic                              first_sel;
   logic                              out_sel_q;
   logic                              out_last_q;
   logic [0:DATA_WIDTH-1][WIDTH-1:0]  dout_re_q;
   logic [0:DATA_WIDTH-1][WIDTH-1:0]  dout_im_q;
   // The first beat goes straight into the output register, so only the
   // second vector of a serialize pair needs a separate holding buffer.
   logic [0:DATA_WIDTH-1][WIDTH-1:0]  sec_re;
   logic [0:DATA_WIDTH-1][WIDTH-1:0]  sec_im;

   logic last_beat;
   logic in_ready;
   logic accept;
   logic advance;

   always_comb begin
      state_nxt = state;
      last_beat = 1'b0;
      in_ready  = 1'b0;
      accept    = 1'b0;
      advance   = 1'b0;

      case (state)
         FIRST:   last_beat = PASS_MODE;
         SECOND:  last_beat = 1'b1;
         default: last_beat = 1'b0;
      endcase

      in_ready = (state == IDLE) || (last_beat && bus.out_ready);
      accept   = bus.in_valid && in_ready;
      advance  = (state == FIRST) && bus.out_ready && !PASS_MODE;

      case (state)
         IDLE: begin
            if (accept) state_nxt = FIRST;
         end
         FIRST: begin
            if (bus.out_ready) begin
               if (!PASS_MODE)  state_nxt = SECOND;
               else if (accept) state_nxt = FIRST;
               else             state_nxt = IDLE;
            end
         end
         SECOND: begin
            if (bus.out_ready) state_nxt = accept ? FIRST : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_sel  <= 1'b0;
         out_sel_q  <= 1'b0;
         out_last_q <= 1'b0;
         dout_re_q  <= '0;
         dout_im_q  <= '0;
         sec_re     <= '0;
         sec_im     <= '0;
      end else if (accept) begin
         first_sel  <= bus.sw;
         out_sel_q  <= bus.sw;
         out_last_q <= PASS_MODE;
         dout_re_q  <= bus.sw ? bus.sub_re : bus.add_re;
         dout_im_q  <= bus.sw ? bus.sub_im : bus.add_im;
         if (!PASS_MODE) begin
            sec_re <= bus.sw ? bus.add_re : bus.sub_re;
            sec_im <= bus.sw ? bus.add_im : bus.sub_im;
         end
      end else if (advance) begin
         out_sel_q  <= ~first_sel;
         out_last_q <= 1'b1;
         dout_re_q  <= sec_re;
         dout_im_q  <= sec_im;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state != IDLE);
   assign bus.out_sel   = out_sel_q;
   assign bus.out_last  = out_last_q;
   assign bus.dout_re   = dout_re_q;
   assign bus.dout_im   = dout_im_q;

endmodule

// File: tb/tb_bf_seq_mux.sv
// tb/tb_bf_seq_mux.sv - directed self-checking bench for bf_seq_mux
module tb_bf_seq_mux;

   localparam int W = 10;
   localparam int N = 16;

   typedef logic [0:N-1][W-1:0] vec_t;

   logic clk = 1'b0;
   logic rst_s;
   logic rst_p;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   bf_seq_mux_if #(.WIDTH(W), .DATA_WIDTH(N)) sbus ();
   bf_seq_mux_if #(.WIDTH(W), .DATA_WIDTH(N)) pbus ();

   bf_seq_mux #(.WIDTH(W), .DATA_WIDTH(N), .PASS_MODE(1'b0)) u_ser (
      .clk (clk),
      .rst (rst_s),
      .bus (sbus)
   );

   bf_seq_mux #(.WIDTH(W), .DATA_WIDTH(N), .PASS_MODE(1'b1)) u_pass (
      .clk (clk),
      .rst (rst_p),
      .bus (pbus)
   );

   function automatic vec_t ramp(input int off, input int mul);
      vec_t v;
      for (int i = 0; i < N; i++) v[i] = W'(mul * (off + i));
      return v;
   endfunction

   function automatic vec_t fill(input int val);
      vec_t v;
      for (int i = 0; i < N; i++) v[i] = W'(val);
      return v;
   endfunction

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input bit pass, input logic v, input logic sel,
                           input logic last, input vec_t re, input vec_t im);
      if (pass) begin
         chk_bit({tag, "_valid"}, pbus.out_valid, v);
         chk_bit({tag, "_sel"},   pbus.out_sel,   sel);
         chk_bit({tag, "_last"},  pbus.out_last,  last);
         chk_vec({tag, "_re"},    pbus.dout_re,   re);
         chk_vec({tag, "_im"},    pbus.dout_im,   im);
      end else begin
         chk_bit({tag, "_valid"}, sbus.out_valid, v);
         chk_bit({tag, "_sel"},   sbus.out_sel,   sel);
         chk_bit({tag, "_last"},  sbus.out_last,  last);
         chk_vec({tag, "_re"},    sbus.dout_re,   re);
         chk_vec({tag, "_im"},    sbus.dout_im,   im);
      end
   endtask

   task automatic drive_s(input logic v, input logic s, input vec_t ar, input vec_t ai,
                          input vec_t sr, input vec_t si);
      sbus.in_valid = v;
      sbus.sw       = s;
      sbus.add_re   = ar;
      sbus.add_im   = ai;
      sbus.sub_re   = sr;
      sbus.sub_im   = si;
   endtask

   task automatic drive_p(input logic v, input logic s, input vec_t ar, input vec_t ai,
                          input vec_t sr, input vec_t si);
      pbus.in_valid = v;
      pbus.sw       = s;
      pbus.add_re   = ar;
      pbus.add_im   = ai;
      pbus.sub_re   = sr;
      pbus.sub_im   = si;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   k;
      int   idx;
      logic bsel;
      logic psw [0:4];

      psw[0] = 1'b0; psw[1] = 1'b1; psw[2] = 1'b1; psw[3] = 1'b0; psw[4] = 1'b1;

      rst_s = 1'b1;
      rst_p = 1'b1;
      drive_s(1'b0, 1'b0, '0, '0, '0, '0);
      drive_p(1'b0, 1'b0, '0, '0, '0, '0);
      sbus.out_ready = 1'b1;
      pbus.out_ready = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk_beat("rst_ser",  1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      chk_beat("rst_pass", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      rst_s = 1'b0;
      rst_p = 1'b0;
      #1;
      chk_bit("rst_ser_in_ready",  sbus.in_ready, 1'b1);
      chk_bit("rst_pass_in_ready", pbus.in_ready, 1'b1);

      // serialize, sw=0: add then sub
      @(negedge clk);
      drive_s(1'b1, 1'b0, ramp(0, 1), ramp(0, -1), ramp(100, 1), ramp(100, -1));
      #1 chk_bit("s0_in_ready", sbus.in_ready, 1'b1);
      @(negedge clk);
      sbus.in_valid = 1'b0;
      #1 chk_beat("s0_b0", 1'b0, 1'b1, 1'b0, 1'b0, ramp(0, 1), ramp(0, -1));
      chk_bit("s0_b0_in_ready", sbus.in_ready, 1'b0);
      @(negedge clk);
      #1 chk_beat("s0_b1", 1'b0, 1'b1, 1'b1, 1'b1, ramp(100, 1), ramp(100, -1));
      @(negedge clk);
      #1 chk_bit("s0_done_valid", sbus.out_valid, 1'b0);

      // serialize, sw=1: sub then add
      drive_s(1'b1, 1'b1, ramp(0, 1), ramp(0, -1), ramp(100, 1), ramp(100, -1));
      @(negedge clk);
      sbus.in_valid = 1'b0;
      #1 chk_beat("s1_b0", 1'b0, 1'b1, 1'b1, 1'b0, ramp(100, 1), ramp(100, -1));
      @(negedge clk);
      #1 chk_beat("s1_b1", 1'b0, 1'b1, 1'b0, 1'b1, ramp(0, 1), ramp(0, -1));
      @(negedge clk);
      #1 chk_bit("s1_done_valid", sbus.out_valid, 1'b0);

      // backpressure during FIRST, with ignored input offered meanwhile
      drive_s(1'b1, 1'b0, ramp(0, 1), ramp(0, -1), ramp(100, 1), ramp(100, -1));
      @(negedge clk);
      drive_s(1'b1, 1'b1, fill(7), fill(7), fill(7), fill(7));
      sbus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk_beat($sformatf("bp_stall%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, ramp(0, 1), ramp(0, -1));
         chk_bit($sformatf("bp_stall%0d_in_ready", i), sbus.in_ready, 1'b0);
         @(negedge clk);
      end
      sbus.out_ready = 1'b1;
      sbus.in_valid  = 1'b0;
      #1 chk_beat("bp_release", 1'b0, 1'b1, 1'b0, 1'b0, ramp(0, 1), ramp(0, -1));
      @(negedge clk);
      #1 chk_beat("bp_b1", 1'b0, 1'b1, 1'b1, 1'b1, ramp(100, 1), ramp(100, -1));
      @(negedge clk);
      #1 chk_bit("bp_done_valid", sbus.out_valid, 1'b0);

      // back-to-back: four inputs, eight beats, no bubbles
      for (int t = 0; t <= 9; t++) begin
         k = (t + 1) / 2;
         drive_s(k < 4, 1'b0, fill(10*k+1), fill(-(10*k+1)), fill(10*k+2), fill(-(10*k+2)));
         #1;
         if (t <= 8) chk_bit($sformatf("b2b_t%0d_in_ready", t), sbus.in_ready, (t % 2) == 0);
         if (t >= 1 && t <= 8) begin
            idx  = (t - 1) / 2;
            bsel = ((t - 1) % 2) == 1;
            chk_beat($sformatf("b2b_t%0d", t), 1'b0, 1'b1, bsel, bsel,
                     bsel ? fill(10*idx+2) : fill(10*idx+1),
                     bsel ? fill(-(10*idx+2)) : fill(-(10*idx+1)));
         end
         if (t == 9) chk_bit("b2b_done_valid", sbus.out_valid, 1'b0);
         @(negedge clk);
      end

      // async reset while a serialize pair is in flight
      drive_s(1'b1, 1'b1, ramp(0, 1), ramp(0, -1), ramp(100, 1), ramp(100, -1));
      @(negedge clk);
      sbus.in_valid = 1'b0;
      #1 chk_beat("ar_pre", 1'b0, 1'b1, 1'b1, 1'b0, ramp(100, 1), ramp(100, -1));
      rst_s = 1'b1;
      #1 chk_beat("ar_ser", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst_s = 1'b0;
      #1 chk_bit("ar_ser_in_ready", sbus.in_ready, 1'b1);
      @(negedge clk);
      #1 chk_bit("ar_ser_no_beat", sbus.out_valid, 1'b0);

      // pass mode: extreme values at full rate
      for (int t = 0; t <= 4; t++) begin
         drive_p(1'b1, psw[t], fill(-512), fill(511), fill(511), fill(-512));
         #1 chk_bit($sformatf("pass_t%0d_in_ready", t), pbus.in_ready, 1'b1);
         if (t >= 1)
            chk_beat($sformatf("pass_t%0d", t), 1'b1, 1'b1, psw[t-1], 1'b1,
                     psw[t-1] ? fill(511) : fill(-512), psw[t-1] ? fill(-512) : fill(511));
         @(negedge clk);
      end
      pbus.in_valid  = 1'b0;
      pbus.out_ready = 1'b0;
      #1 chk_beat("pass_pending", 1'b1, 1'b1, 1'b1, 1'b1, fill(511), fill(-512));
      rst_p = 1'b1;
      #1 chk_beat("pass_rst", 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst_p = 1'b0;
      pbus.out_ready = 1'b1;
      #1 chk_bit("pass_rst_in_ready", pbus.in_ready, 1'b1);
      chk_bit("pass_rst_valid", pbus.out_valid, 1'b0);
      @(negedge clk);
      #1 chk_bit("pass_rst_no_beat", pbus.out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
